// File: rtl/mem_access_if.sv
// ============================================================================
// Module      : mem_access_if
// Description : Bundles the upstream start/complete handshake and the
//               single-port data-memory bus of the load/store stage.
//               master : the environment side (ALU stage + data memory)
//               slave  : the mem_access stage itself
// Ports       : enabled/is_load/is_store/funct3/addr/wdata   upstream request
//               completed/rd/fault                           upstream result
//               mem_req/mem_we/mem_wstrb/mem_addr/mem_wdata  memory request
//               mem_ready/mem_rvalid/mem_rdata               memory response
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_access_if #(
  parameter int ADDR_W = 15
);
  logic              enabled;
  logic              is_load;
  logic              is_store;
  logic [2:0]        funct3;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              completed;
  logic [31:0]       rd;
  logic              fault;
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output enabled, is_load, is_store, funct3, addr, wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  completed, rd, fault,
    input  mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata
  );

  modport slave (
    input  enabled, is_load, is_store, funct3, addr, wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output completed, rd, fault,
    output mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_access.sv
// ============================================================================
// Module      : mem_access
// Description : Load/store stage following the ALU. Turns the ALU result into
//               one data-memory transaction with store lane steering and load
//               lane extraction plus sign/zero extension. Non-memory ops pass
//               the ALU result straight through to rd.
// Ports       : clk  - clock, all state updates on the rising edge
//               rst  - synchronous active-high reset
//               bus  - mem_access_if.slave (upstream handshake + memory bus)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access #(
  parameter int ADDR_W = 15
) (
  input  logic          clk,
  input  logic          rst,
  mem_access_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            r_state,     w_state_n;
  logic [2:0]        r_funct3,    w_funct3_n;
  logic [1:0]        r_lane,      w_lane_n;
  logic              r_completed, w_completed_n;
  logic              r_fault,     w_fault_n;
  logic [31:0]       r_rd,        w_rd_n;
  logic              r_mem_req,   w_mem_req_n;
  logic              r_mem_we,    w_mem_we_n;
  logic [3:0]        r_mem_wstrb, w_mem_wstrb_n;
  logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_n;
  logic [31:0]       r_mem_wdata, w_mem_wdata_n;

  logic              w_misalign;
  logic              w_bad_f3;
  logic              w_bad;
  logic [3:0]        w_st_wstrb;
  logic [31:0]       w_st_wdata;
  logic [31:0]       w_shifted;
  logic [31:0]       w_load_data;

  // Request decode, evaluated on the cycle enabled is high.
  always_comb begin
    w_misalign = 1'b0;
    w_st_wstrb = 4'hF;
    w_st_wdata = bus.wdata;
    case (bus.funct3[1:0])
      2'b00: begin
        w_st_wstrb = 4'b0001 << bus.addr[1:0];
        w_st_wdata = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        w_misalign = bus.addr[0];
        w_st_wstrb = 4'b0011 << bus.addr[1:0];
        w_st_wdata = {2{bus.wdata[15:0]}};
      end
      2'b10:   w_misalign = |bus.addr[1:0];
      default: ;
    endcase
    // Loads accept 000/001/010/100/101; stores accept 000/001/010.
    w_bad_f3 = bus.is_load ? ((bus.funct3 == 3'b011) || (bus.funct3[2:1] == 2'b11))
                           : (bus.funct3 >= 3'b011);
    w_bad    = (bus.is_load & bus.is_store) | w_bad_f3 | w_misalign;
  end

  // Load lane extraction uses the byte offset captured at issue time.
  always_comb begin
    w_shifted = bus.mem_rdata >> {r_lane, 3'b000};
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
      3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
      default: w_load_data = bus.mem_rdata;
    endcase
  end

  always_comb begin
    w_state_n     = r_state;
    w_funct3_n    = r_funct3;
    w_lane_n      = r_lane;
    w_completed_n = 1'b0;
    w_fault_n     = r_fault;
    w_rd_n        = r_rd;
    w_mem_req_n   = r_mem_req;
    w_mem_we_n    = r_mem_we;
    w_mem_wstrb_n = r_mem_wstrb;
    w_mem_addr_n  = r_mem_addr;
    w_mem_wdata_n = r_mem_wdata;

    case (r_state)
      S_IDLE: begin
        if (bus.enabled) begin
          w_funct3_n = bus.funct3;
          w_lane_n   = bus.addr[1:0];
          if (!bus.is_load && !bus.is_store) begin
            w_state_n     = S_DONE;
            w_completed_n = 1'b1;
            w_rd_n        = bus.addr;
            w_fault_n     = 1'b0;
          end else if (w_bad) begin
            w_state_n     = S_DONE;
            w_completed_n = 1'b1;
            w_rd_n        = 32'd0;
            w_fault_n     = 1'b1;
          end else begin
            w_state_n     = S_REQ;
            w_mem_req_n   = 1'b1;
            w_mem_we_n    = bus.is_store;
            w_mem_addr_n  = bus.addr[ADDR_W+1:2];
            w_mem_wstrb_n = bus.is_store ? w_st_wstrb : 4'h0;
            if (bus.is_store) begin
              w_mem_wdata_n = w_st_wdata;
            end
          end
        end
      end
      S_REQ: begin
        if (bus.mem_ready) begin
          w_mem_req_n = 1'b0;
          w_mem_we_n  = 1'b0;
          if (r_mem_we) begin
            w_state_n     = S_DONE;
            w_completed_n = 1'b1;
            w_fault_n     = 1'b0;
          end else begin
            w_state_n = S_WAIT_R;
          end
        end
      end
      S_WAIT_R: begin
        if (bus.mem_rvalid) begin
          w_state_n     = S_DONE;
          w_completed_n = 1'b1;
          w_rd_n        = w_load_data;
          w_fault_n     = 1'b0;
        end
      end
      default: begin
        // S_DONE: completed is high for this one cycle only.
        w_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_funct3    <= 3'd0;
      r_lane      <= 2'd0;
      r_completed <= 1'b0;
      r_fault     <= 1'b0;
      r_rd        <= 32'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_wstrb <= 4'd0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
    end else begin
      r_state     <= w_state_n;
      r_funct3    <= w_funct3_n;
      r_lane      <= w_lane_n;
      r_completed <= w_completed_n;
      r_fault     <= w_fault_n;
      r_rd        <= w_rd_n;
      r_mem_req   <= w_mem_req_n;
      r_mem_we    <= w_mem_we_n;
      r_mem_wstrb <= w_mem_wstrb_n;
      r_mem_addr  <= w_mem_addr_n;
      r_mem_wdata <= w_mem_wdata_n;
    end
  end

  assign bus.completed = r_completed;
  assign bus.fault     = r_fault;
  assign bus.rd        = r_rd;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_wstrb = r_mem_wstrb;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// ============================================================================
// Module      : tb_mem_access
// Description : Directed self-checking bench for mem_access. A small word
//               memory model answers requests with configurable ready/rvalid
//               stalls; expected values are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access;
  localparam int ADDR_W = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0]       tmem [0:255];
  int                n_checks = 0;
  int                n_errors = 0;

  int                res_lat;
  int                res_req_n;
  logic              res_unstable;
  logic              res_we;
  logic [ADDR_W-1:0] res_addr;
  logic [3:0]        res_wstrb;
  logic [31:0]       res_wdata;
  logic [31:0]       res_rd;
  logic              res_fault;
  logic              seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op at posedge+1 and serve the memory bus until completed.
  task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int rdy_stall, input int rv_stall);
    int   req_n;
    int   rwait;
    logic in_wait;
    logic will_acc;
    logic was_rv;
    req_n = 0; rwait = 0; in_wait = 1'b0;
    res_unstable = 1'b0; res_we = 1'b0; res_addr = '0; res_wstrb = 4'd0; res_wdata = 32'd0;
    bus.enabled = 1'b1; bus.is_load = ld; bus.is_store = st;
    bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
    @(posedge clk); #1;
    bus.enabled = 1'b0;
    bus.addr = 32'hFFFF_FFFF; bus.wdata = 32'h5A5A_5A5A;
    res_lat = 1;
    while (!bus.completed && res_lat < 40) begin
      if (bus.mem_req) begin
        if (req_n == 0) begin
          res_we = bus.mem_we; res_addr = bus.mem_addr;
          res_wstrb = bus.mem_wstrb; res_wdata = bus.mem_wdata;
        end else if (bus.mem_we !== res_we || bus.mem_addr !== res_addr ||
                     bus.mem_wstrb !== res_wstrb || bus.mem_wdata !== res_wdata) begin
          res_unstable = 1'b1;
        end
        req_n++;
        bus.mem_ready = (req_n > rdy_stall);
      end else begin
        bus.mem_ready = 1'b0;
      end
      if (in_wait) begin
        bus.mem_rvalid = (rwait >= rv_stall);
        bus.mem_rdata  = tmem[res_addr[7:0]];
        rwait++;
      end else begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'hDEAD_BEEF;
      end
      will_acc = bus.mem_req && bus.mem_ready;
      was_rv   = bus.mem_rvalid;
      if (will_acc && res_we) begin
        for (int i = 0; i < 4; i++) begin
          if (res_wstrb[i]) tmem[res_addr[7:0]][8*i +: 8] = res_wdata[8*i +: 8];
        end
      end
      @(posedge clk); #1;
      res_lat++;
      if (will_acc && !res_we) begin in_wait = 1'b1; rwait = 0; end
      if (was_rv) in_wait = 1'b0;
    end
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;
    res_req_n = req_n; res_rd = bus.rd; res_fault = bus.fault;
    check("completed_seen", {31'd0, bus.completed}, 32'd1);
    @(posedge clk); #1;
    check("completed_single_pulse", {31'd0, bus.completed}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.enabled = 1'b0; bus.is_load = 1'b0; bus.is_store = 1'b0; bus.funct3 = 3'd0;
    bus.addr = 32'd0; bus.wdata = 32'd0;
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
    for (int i = 0; i < 256; i++) tmem[i] = 32'd0;
    tmem[8'h80] = 32'h80FF_0000;
    tmem[8'h04] = 32'h1111_1111;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_completed", {31'd0, bus.completed}, 32'd0);
    check("rst_fault",     {31'd0, bus.fault},     32'd0);
    check("rst_mem_req",   {31'd0, bus.mem_req},   32'd0);
    check("rst_rd",        bus.rd,                 32'd0);
    check("rst_wstrb",     {28'd0, bus.mem_wstrb}, 32'd0);

    // Non-memory pass-through
    do_op(1'b0, 1'b0, 3'b010, 32'h1234_5678, 32'd0, 0, 0);
    check("nonmem_lat",   res_lat,   1);
    check("nonmem_rd",    res_rd,    32'h1234_5678);
    check("nonmem_fault", {31'd0, res_fault}, 32'd0);
    check("nonmem_noreq", res_req_n, 0);

    // SB with ready held low for 3 cycles
    do_op(1'b0, 1'b1, 3'b000, 32'h0000_0106, 32'hAABB_CCDD, 3, 0);
    check("sb_req_cycles", res_req_n, 4);
    check("sb_stable",     {31'd0, res_unstable}, 32'd0);
    check("sb_we",         {31'd0, res_we}, 32'd1);
    check("sb_addr",       {17'd0, res_addr}, 32'h41);
    check("sb_wstrb",      {28'd0, res_wstrb}, 32'h4);
    check("sb_wdata",      res_wdata, 32'hDDDD_DDDD);
    check("sb_lat",        res_lat, 5);
    check("sb_fault",      {31'd0, res_fault}, 32'd0);

    // Byte/half loads with extension
    do_op(1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'd0, 0, 0);
    check("lb_rd",    res_rd, 32'hFFFF_FF80);
    check("lb_lat",   res_lat, 3);
    check("lb_we",    {31'd0, res_we}, 32'd0);
    check("lb_wstrb", {28'd0, res_wstrb}, 32'd0);
    check("lb_addr",  {17'd0, res_addr}, 32'h80);
    do_op(1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'd0, 0, 0);
    check("lbu_rd", res_rd, 32'h0000_0080);
    do_op(1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'd0, 0, 0);
    check("lh_rd", res_rd, 32'hFFFF_80FF);
    do_op(1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'd0, 0, 0);
    check("lhu_rd", res_rd, 32'h0000_80FF);

    // Faults: complete after one cycle, rd=0, no memory access
    do_op(1'b1, 1'b0, 3'b010, 32'h0000_0002, 32'd0, 0, 0);
    check("lw_mis_fault", {31'd0, res_fault}, 32'd1);
    check("lw_mis_rd",    res_rd, 32'd0);
    check("lw_mis_noreq", res_req_n, 0);
    check("lw_mis_lat",   res_lat, 1);
    check("fault_holds",  {31'd0, bus.fault}, 32'd1);
    do_op(1'b0, 1'b1, 3'b001, 32'h0000_0001, 32'h1234_5678, 0, 0);
    check("sh_mis_fault", {31'd0, res_fault}, 32'd1);
    check("sh_mis_noreq", res_req_n, 0);
    do_op(1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'd0, 0, 0);
    check("ld_f3_fault", {31'd0, res_fault}, 32'd1);
    check("ld_f3_noreq", res_req_n, 0);
    do_op(1'b0, 1'b1, 3'b011, 32'h0000_0000, 32'd0, 0, 0);
    check("st_f3_fault", {31'd0, res_fault}, 32'd1);
    do_op(1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'd0, 0, 0);
    check("both_fault", {31'd0, res_fault}, 32'd1);
    check("both_noreq", res_req_n, 0);
    do_op(1'b0, 1'b0, 3'b000, 32'hCAFE_0001, 32'd0, 0, 0);
    check("fault_clears", {31'd0, res_fault}, 32'd0);

    // Back-to-back stores and loads through the memory model
    do_op(1'b0, 1'b1, 3'b001, 32'h0000_0012, 32'h1234_BEEF, 0, 0);
    check("sh_wstrb", {28'd0, res_wstrb}, 32'hC);
    check("sh_wdata", res_wdata, 32'hBEEF_BEEF);
    check("sh_lat",   res_lat, 2);
    do_op(1'b1, 1'b0, 3'b101, 32'h0000_0012, 32'd0, 0, 0);
    check("b2b_lhu", res_rd, 32'h0000_BEEF);
    do_op(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'd0, 1, 2);
    check("b2b_lw",     res_rd, 32'hBEEF_1111);
    check("b2b_lw_lat", res_lat, 6);
    do_op(1'b1, 1'b0, 3'b100, 32'h0000_0011, 32'd0, 0, 0);
    check("b2b_lbu", res_rd, 32'h0000_0011);
    do_op(1'b1, 1'b0, 3'b000, 32'h0000_0013, 32'd0, 0, 0);
    check("b2b_lb", res_rd, 32'hFFFF_FFBE);
    do_op(1'b0, 1'b1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D, 0, 0);
    check("sw_wstrb", {28'd0, res_wstrb}, 32'hF);
    check("sw_wdata", res_wdata, 32'hCAFE_F00D);
    check("sw_addr",  {17'd0, res_addr}, 32'h8);
    do_op(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'd0, 0, 1);
    check("sw_lw", res_rd, 32'hCAFE_F00D);

    // Reset while waiting for read data, then a stray rvalid
    bus.enabled = 1'b1; bus.is_load = 1'b1; bus.is_store = 1'b0;
    bus.funct3 = 3'b010; bus.addr = 32'h0000_0020;
    @(posedge clk); #1;
    bus.enabled = 1'b0;
    check("rstmid_req", {31'd0, bus.mem_req}, 32'd1);
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    check("rstmid_accepted", {31'd0, bus.mem_req}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = bus.completed;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h7777_7777;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.completed) seen = 1'b1;
    end
    bus.mem_rvalid = 1'b0;
    check("rstmid_no_completed", {31'd0, seen}, 32'd0);
    check("rstmid_rd",    bus.rd, 32'd0);
    check("rstmid_fault", {31'd0, bus.fault}, 32'd0);
    check("rstmid_req0",  {31'd0, bus.mem_req}, 32'd0);
    check("rstmid_we",    {31'd0, bus.mem_we}, 32'd0);
    check("rstmid_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
    check("rstmid_addr",  {17'd0, bus.mem_addr}, 32'd0);
    check("rstmid_wdata", bus.mem_wdata, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
